// File: rtl/fetch_sched_if.sv
// fetch_sched_if: bus bundle around the multithreaded fetch stage.
// Groups the I-TLB/I-cache side, the F/D outputs to hzu, the isvalid
// feedback, fill notifications and the redirect port.
//   master : the fetch stage (drives fetch_pc/req and the F/D outputs)
//   slave  : the environment (memories, hzu, redirect source)
interface fetch_sched_if #(
    parameter int NTHREADS = 4,
    parameter int PC_W     = 32
);
    localparam int TW = $clog2(NTHREADS);

    logic [PC_W-1:0]     fetch_pc;
    logic                fetch_req;
    logic [31:0]         imem_instr;
    logic                imem_itlb_miss;
    logic                imem_icache_miss;
    logic [NTHREADS-1:0] fill_done;
    logic [TW-1:0]       thread;
    logic [31:0]         instr;
    logic                itlb_miss;
    logic                icache_miss;
    logic                isvalid;
    logic                redirect_valid;
    logic [TW-1:0]       redirect_thread;
    logic [PC_W-1:0]     redirect_pc;

    modport master (
        output fetch_pc, fetch_req,
        output thread, instr, itlb_miss, icache_miss,
        input  imem_instr, imem_itlb_miss, imem_icache_miss,
        input  fill_done, isvalid,
        input  redirect_valid, redirect_thread, redirect_pc
    );

    modport slave (
        input  fetch_pc, fetch_req,
        input  thread, instr, itlb_miss, icache_miss,
        output imem_instr, imem_itlb_miss, imem_icache_miss,
        output fill_done, isvalid,
        output redirect_valid, redirect_thread, redirect_pc
    );
endinterface

// File: rtl/fetch_sched.sv
// fetch_sched: round-robin multithreaded fetch stage feeding hzu.
// Ports: clk, rst (sync, active-high), bus (fetch_sched_if.master);
// with FETCH_PERF_CNT_EN defined also perf_fetched/replays/misses (32b).
module fetch_sched #(
    parameter int              NTHREADS = 4,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_1000)
) (
    input  logic clk,
    input  logic rst,
    fetch_sched_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_replays,
    output logic [31:0] perf_misses
`endif
);
    localparam int TW = $clog2(NTHREADS);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MISSWAIT = 2'd1,
        TRAP     = 2'd2
    } tstate_e;

    tstate_e         st_q [NTHREADS];
    tstate_e         st_d [NTHREADS];
    logic [PC_W-1:0] pc_q [NTHREADS];
    logic [PC_W-1:0] pc_d [NTHREADS];
    logic [TW-1:0]   last_q, last_d;

    // F/D register; together with a_pc_q it is in-flight stage A
    logic            fd_vld_q, fd_vld_d;
    logic [TW-1:0]   fd_thr_q, fd_thr_d;
    logic [31:0]     fd_instr_q, fd_instr_d;
    logic            fd_itlb_q, fd_itlb_d;
    logic            fd_ic_q, fd_ic_d;
    logic [PC_W-1:0] a_pc_q, a_pc_d;

    // stage B: the entry hzu is judging this cycle
    logic            b_vld_q, b_vld_d;
    logic [TW-1:0]   b_thr_q, b_thr_d;
    logic [PC_W-1:0] b_pc_q, b_pc_d;
    logic            b_itlb_q, b_itlb_d;
    logic            b_ic_q, b_ic_d;

    logic                vrd_fire;
    logic                vrd_ovr;
    logic                vrd_act;
    logic [NTHREADS-1:0] kill;
    logic [NTHREADS-1:0] elig;
    logic                squash_a;
    logic                found;
    logic [TW-1:0]       sel;
    logic [TW-1:0]       idx;
    logic                req;

    // Non-retire verdict; a redirect to the same thread takes over.
    assign vrd_fire = b_vld_q && !bus.isvalid;
    assign vrd_ovr  = bus.redirect_valid &&
                      (bus.redirect_thread == b_thr_q);
    assign vrd_act  = vrd_fire && !vrd_ovr;

    always_comb begin
        kill = '0;
        if (vrd_fire) begin
            kill[b_thr_q] = 1'b1;
        end
        if (bus.redirect_valid) begin
            kill[bus.redirect_thread] = 1'b1;
        end
    end

    assign squash_a = fd_vld_q && kill[fd_thr_q];

    always_comb begin
        elig = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            elig[t] = (st_q[t] == RUN) && !kill[t];
        end
    end

    // Round-robin search beginning just after the last pick.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NTHREADS; i++) begin
            idx = last_q + TW'(i);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign req           = found && !rst;
    assign bus.fetch_req = req;
    assign bus.fetch_pc  = pc_q[sel];

    assign bus.thread      = fd_thr_q;
    assign bus.instr       = fd_instr_q;
    assign bus.itlb_miss   = fd_itlb_q;
    assign bus.icache_miss = fd_ic_q | squash_a;

    // Per-thread run state and PC next-state.
    always_comb begin
        for (int t = 0; t < NTHREADS; t++) begin
            st_d[t] = st_q[t];
            pc_d[t] = pc_q[t];
        end
        last_d = last_q;
        if (req) begin
            pc_d[sel] = pc_q[sel] + PC_W'(4);
            last_d    = sel;
        end
        for (int t = 0; t < NTHREADS; t++) begin
            if (bus.fill_done[t] && st_q[t] == MISSWAIT) begin
                st_d[t] = RUN;
            end
        end
        if (vrd_act) begin
            pc_d[b_thr_q] = b_pc_q;
            unique case (1'b1)
                b_itlb_q: st_d[b_thr_q] = TRAP;
                b_ic_q:   st_d[b_thr_q] = MISSWAIT;
                default:  st_d[b_thr_q] = st_q[b_thr_q];
            endcase
        end
        if (bus.redirect_valid) begin
            pc_d[bus.redirect_thread] = bus.redirect_pc;
            st_d[bus.redirect_thread] = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                st_q[t] <= RUN;
            end
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                st_q[t] <= st_d[t];
            end
        end
    end

    // F/D load (bubble when nothing selected) and in-flight shift.
    always_comb begin
        fd_vld_d   = 1'b0;
        fd_thr_d   = '0;
        fd_instr_d = '0;
        fd_itlb_d  = 1'b0;
        fd_ic_d    = 1'b1;
        a_pc_d     = '0;
        if (req) begin
            fd_vld_d   = 1'b1;
            fd_thr_d   = sel;
            fd_instr_d = bus.imem_instr;
            fd_itlb_d  = bus.imem_itlb_miss;
            fd_ic_d    = bus.imem_icache_miss;
            a_pc_d     = pc_q[sel];
        end
        b_vld_d  = fd_vld_q && !squash_a;
        b_thr_d  = fd_thr_q;
        b_pc_d   = a_pc_q;
        b_itlb_d = fd_itlb_q;
        b_ic_d   = fd_ic_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                pc_q[t] <= RESET_PC;
            end
            last_q     <= TW'(NTHREADS - 1);
            fd_vld_q   <= 1'b0;
            fd_thr_q   <= '0;
            fd_instr_q <= '0;
            fd_itlb_q  <= 1'b0;
            fd_ic_q    <= 1'b1;
            a_pc_q     <= '0;
            b_vld_q    <= 1'b0;
            b_thr_q    <= '0;
            b_pc_q     <= '0;
            b_itlb_q   <= 1'b0;
            b_ic_q     <= 1'b0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                pc_q[t] <= pc_d[t];
            end
            last_q     <= last_d;
            fd_vld_q   <= fd_vld_d;
            fd_thr_q   <= fd_thr_d;
            fd_instr_q <= fd_instr_d;
            fd_itlb_q  <= fd_itlb_d;
            fd_ic_q    <= fd_ic_d;
            a_pc_q     <= a_pc_d;
            b_vld_q    <= b_vld_d;
            b_thr_q    <= b_thr_d;
            b_pc_q     <= b_pc_d;
            b_itlb_q   <= b_itlb_d;
            b_ic_q     <= b_ic_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        vrd_retire;
    logic        inc_rep;
    logic        inc_miss;
    logic [31:0] fetched_q, replays_q, misses_q;

    assign vrd_retire = b_vld_q && bus.isvalid;
    assign inc_rep    = vrd_act && !b_itlb_q && !b_ic_q;
    assign inc_miss   = vrd_act && (b_itlb_q || b_ic_q);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            replays_q <= '0;
            misses_q  <= '0;
        end else begin
            if (vrd_retire && fetched_q != '1) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (inc_rep && replays_q != '1) begin
                replays_q <= replays_q + 32'd1;
            end
            if (inc_miss && misses_q != '1) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_replays = replays_q;
    assign perf_misses  = misses_q;
`endif
endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed cycle-by-cycle bench for fetch_sched.
// Drives imem/hzu/fill/redirect inputs and checks hand-computed outputs.
module tb_fetch_sched;
    logic clk;
    logic rst;
    int   nerr;
    int   nchk;

    fetch_sched_if #(.NTHREADS(4), .PC_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_replays;
    logic [31:0] perf_misses;
`endif

    fetch_sched #(
        .NTHREADS(4),
        .PC_W(32),
        .RESET_PC(32'h0000_1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_replays(perf_replays),
        .perf_misses(perf_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // I-cache data is a recognisable function of the address.
    always_comb bus.imem_instr = bus.fetch_pc | 32'h1300_0000;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic iv, input logic ic,
                       input logic tl, input logic [3:0] fd,
                       input logic rv, input logic [1:0] rt,
                       input logic [31:0] rpc);
        rst                  = r;
        bus.isvalid          = iv;
        bus.imem_icache_miss = ic;
        bus.imem_itlb_miss   = tl;
        bus.fill_done        = fd;
        bus.redirect_valid   = rv;
        bus.redirect_thread  = rt;
        bus.redirect_pc      = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        drv(1, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("rst_req0", 32'(bus.fetch_req), 32'd0);
        tick();
        drv(1, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("rst_req", 32'(bus.fetch_req), 32'd0);
        chk("rst_thr", 32'(bus.thread), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_itlb", 32'(bus.itlb_miss), 32'd0);
        chk("rst_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        // C0..C4: plain round-robin
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c0_req", 32'(bus.fetch_req), 32'd1);
        chk("c0_pc", bus.fetch_pc, 32'h1000);
        tick();
        drv(0, 1, 1, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c1_pc", bus.fetch_pc, 32'h1000);
        chk("c1_thr", 32'(bus.thread), 32'd0);
        chk("c1_instr", bus.instr, 32'h1300_1000);
        chk("c1_ic", 32'(bus.icache_miss), 32'd0);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c2_pc", bus.fetch_pc, 32'h1000);
        chk("c2_thr", 32'(bus.thread), 32'd1);
        chk("c2_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        drv(0, 0, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c3_pc", bus.fetch_pc, 32'h1000);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c4_pc", bus.fetch_pc, 32'h1004);
        tick();
        // t1 in MISSWAIT is skipped
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c5_skip_t1", bus.fetch_pc, 32'h1004);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c6_pc", bus.fetch_pc, 32'h1004);
        tick();
        // data-race verdict for t2@0x1004
        drv(0, 0, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c7_pc", bus.fetch_pc, 32'h1008);
        tick();
        drv(0, 1, 0, 0, 4'b0010, 0, 2'd0, 32'h0);
        chk("c8_replay", bus.fetch_pc, 32'h1004);
`ifdef FETCH_PERF_CNT_EN
        chk("c8_perf_rep", perf_replays, 32'd1);
        chk("c8_perf_miss", perf_misses, 32'd1);
        chk("c8_perf_fet", perf_fetched, 32'd4);
`endif
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c9_pc", bus.fetch_pc, 32'h1008);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c10_pc", bus.fetch_pc, 32'h100C);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c11_t1_refetch", bus.fetch_pc, 32'h1000);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c12_pc", bus.fetch_pc, 32'h1008);
        tick();
        // itlb miss on t3
        drv(0, 1, 0, 1, 4'd0, 0, 2'd0, 32'h0);
        chk("c13_pc", bus.fetch_pc, 32'h100C);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c14_itlb", 32'(bus.itlb_miss), 32'd1);
        chk("c14_thr", 32'(bus.thread), 32'd3);
        chk("c14_pc", bus.fetch_pc, 32'h1010);
        tick();
        // verdict and redirect for t3 in the same cycle
        drv(0, 0, 0, 0, 4'd0, 1, 2'd3, 32'h8000);
        chk("c15_pc", bus.fetch_pc, 32'h1004);
        chk("c15_ic", 32'(bus.icache_miss), 32'd0);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c16_pc", bus.fetch_pc, 32'h100C);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c17_redir", bus.fetch_pc, 32'h8000);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c18_pc", bus.fetch_pc, 32'h1014);
        tick();
        // park t1, t2, t3 on misses
        drv(0, 1, 1, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c19_pc", bus.fetch_pc, 32'h1008);
        tick();
        drv(0, 1, 1, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c20_pc", bus.fetch_pc, 32'h1010);
        tick();
        drv(0, 0, 1, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c21_pc", bus.fetch_pc, 32'h8004);
        tick();
        drv(0, 0, 0, 0, 4'd0, 1, 2'd0, 32'h1000);
        chk("c22_pc", bus.fetch_pc, 32'h8008);
        tick();
        drv(0, 0, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c23_squash_ic", 32'(bus.icache_miss), 32'd1);
        chk("c23_thr", 32'(bus.thread), 32'd3);
        chk("c23_pc", bus.fetch_pc, 32'h1000);
        tick();
        // t0 is the only runnable thread
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c24_pc", bus.fetch_pc, 32'h1004);
        chk("c24_ic", 32'(bus.icache_miss), 32'd0);
        tick();
        drv(0, 0, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c25_squash_ic", 32'(bus.icache_miss), 32'd1);
        chk("c25_req", 32'(bus.fetch_req), 32'd0);
        tick();
        drv(0, 1, 1, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c26_req", 32'(bus.fetch_req), 32'd1);
        chk("c26_refetch", bus.fetch_pc, 32'h1000);
        chk("c26_bubble_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c27_pc", bus.fetch_pc, 32'h1004);
        chk("c27_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        // every thread waiting on a fill
        drv(0, 0, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c28_req", 32'(bus.fetch_req), 32'd0);
        chk("c28_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        drv(0, 1, 0, 0, 4'b0100, 0, 2'd0, 32'h0);
        chk("c29_req", 32'(bus.fetch_req), 32'd0);
        chk("c29_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c30_req", 32'(bus.fetch_req), 32'd1);
        chk("c30_pc", bus.fetch_pc, 32'h1010);
        chk("c30_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c31_thr", 32'(bus.thread), 32'd2);
        chk("c31_ic", 32'(bus.icache_miss), 32'd0);
        chk("c31_instr", bus.instr, 32'h1300_1010);
        chk("c31_pc", bus.fetch_pc, 32'h1014);
        tick();
        // reset while three threads are parked
        drv(1, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c32_req", 32'(bus.fetch_req), 32'd0);
        tick();
        drv(0, 1, 0, 0, 4'd0, 0, 2'd0, 32'h0);
        chk("c33_req", 32'(bus.fetch_req), 32'd1);
        chk("c33_pc", bus.fetch_pc, 32'h1000);
        chk("c33_ic", 32'(bus.icache_miss), 32'd1);
        tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fetch_sched.md
Name: fetch_sched

Overview:
Multithreaded instruction fetch stage, directly upstream of the hazard unit (hzu).
- Keeps one PC and one run state per hardware thread.
- Picks one runnable thread per cycle (round-robin) and drives its PC to the I-TLB/I-cache, which answer combinationally.
- Registers {thread, instr, itlb_miss, icache_miss} into the F/D register consumed by hzu.
- Uses hzu's isvalid feedback to replay instructions rejected for data races, and parks threads that miss.

Parameters:
NTHREADS, 4, number of hardware threads (power of 2, >=2)
PC_W, 32, PC width in bits
RESET_PC, 32'h0000_1000, PC of every thread after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_pc  out  PC_W  address to I-TLB/I-cache this cycle
fetch_req  out  1  a thread was selected this cycle
imem_instr  in  32  I-cache data for fetch_pc (same cycle)
imem_itlb_miss  in  1  I-TLB miss for fetch_pc (same cycle)
imem_icache_miss  in  1  I-cache miss for fetch_pc (same cycle)
fill_done  in  NTHREADS  one-cycle pulse: miss for thread t serviced
thread  out  $clog2(NTHREADS)  thread id to hzu
instr  out  32  instruction to hzu
itlb_miss  out  1  to hzu
icache_miss  out  1  to hzu; also forced high for bubbles/squashes
isvalid  in  1  hzu verdict on the instruction presented the previous cycle
redirect_valid  in  1  branch/exception redirect
redirect_thread  in  $clog2(NTHREADS)  thread to redirect
redirect_pc  in  PC_W  new PC

Behaviour:
- One clock domain (clk). rst is synchronous, active-high.
- Reset values:
  - All PCs = RESET_PC; all thread states = RUN; last-selected pointer = NTHREADS-1.
  - F/D register invalid; thread=0, instr=0, itlb_miss=0, icache_miss=1. A bubble always drives icache_miss=1.
  - fetch_req=0 during the reset cycle. In-flight record invalid.
- Per-thread state machine:
  - RUN -> MISSWAIT on an icache_miss verdict.
  - RUN -> TRAP on an itlb_miss verdict.
  - MISSWAIT -> RUN on fill_done[t].
  - Any state -> RUN on a redirect to t.
- Selection: combinational round-robin starting at last+1. Eligible threads are in RUN, not masked by a squash this cycle, and not the target of redirect_valid this cycle. If none is eligible: fetch_req=0 and a bubble is loaded.
- Fetch cycle N:
  - Selected PC drives fetch_pc.
  - At the edge, the F/D register loads {sel, imem_instr, imem_itlb_miss, imem_icache_miss}, and the selected PC advances by 4 (wraps modulo 2^PC_W).
  - The in-flight record shifts {valid, thread, pc}: stage A holds what is presented to hzu; stage B holds what hzu judged last cycle.
- Verdict at N+2 (isvalid vs stage B):
  - isvalid=1: retire record, no action.
  - isvalid=0 with the recorded itlb_miss: thread -> TRAP, PC := recorded pc.
  - isvalid=0 with the recorded icache_miss and the record was not a bubble: thread -> MISSWAIT, PC := recorded pc.
  - isvalid=0 otherwise (data race): PC := recorded pc, thread stays RUN (replay).
- Squash: on any non-retire verdict for thread T, if F/D currently holds T, force icache_miss=1 on the hzu outputs combinationally and invalidate stage A. T is also masked from selection this cycle.
- Redirect: PC[t] := redirect_pc and state := RUN at the edge. Same squash of in-flight entries of t.
- Priority: redirect to T overrides a same-cycle verdict for T.
- fill_done for a thread not in MISSWAIT is ignored.
- rst mid-miss returns all threads to RUN at RESET_PC and drops all in-flight records.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32), perf_replays (32), perf_misses (32).
  - perf_fetched: count of retire verdicts.
  - perf_replays: count of data-race replays.
  - perf_misses: count of MISSWAIT+TRAP entries.
  - All saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, no misses, isvalid=1 always -> fetch_pc sequence 0x1000(t0), 0x1000(t1), 0x1000(t2), 0x1000(t3), 0x1004(t0).
- t1 fetch at 0x1000 returns imem_icache_miss=1 -> t1 skipped by round-robin until fill_done[1]; next t1 fetch_pc=0x1000.
- isvalid=0 for t2 at 0x1004 with no miss bits -> next t2 fetch_pc=0x1004; perf_replays=1 when FETCH_PERF_CNT_EN defined.
- NTHREADS set so t0 is the only RUN thread, back-to-back, isvalid=0 on 0x1000 -> F/D copy of 0x1004 squashed (icache_miss=1 to hzu); t0 refetches 0x1000.
- itlb miss on t3, then redirect_valid t3 to 0x8000 in the same cycle as its verdict -> t3 RUN, next t3 fetch_pc=0x8000.
- All threads in MISSWAIT -> fetch_req=0 and bubbles (icache_miss=1) until fill_done, then fetch resumes.
